// File: rtl/prbs9_checker_pkg.sv
// ============================================================================
// prbs9_checker_pkg: shared PRBS9 constants, FSM encoding and tap helper
// Rev 1.0
// ============================================================================
`default_nettype none

package prbs9_checker_pkg;

    localparam int PRBS9_LEN = 9;
    localparam int TAP_HI    = 9;
    localparam int TAP_LO    = 5;
    localparam int LOSS_W    = 8;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // h[0] is the newest bit, so tap n lives at index n-1.
    function automatic logic prbs9_pred(input logic [PRBS9_LEN-1:0] h);
        return h[TAP_HI-1] ^ h[TAP_LO-1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs9_checker_if.sv
// ============================================================================
// prbs9_checker_if: symbol/control inputs and BER status outputs of the checker
// Rev 1.0
// ============================================================================
`default_nettype none

interface prbs9_checker_if
    import prbs9_checker_pkg::*;
#(
    parameter int NB_COUNT = 64
);
    logic                i_valid;
    logic                i_enable;
    logic                i_bit;
    logic                i_clear;
    logic                o_lock;
    logic [1:0]          o_state;
    logic [NB_COUNT-1:0] o_errors;
    logic [NB_COUNT-1:0] o_bits;
    logic [LOSS_W-1:0]   o_lock_losses;

    modport master (
        output i_valid, i_enable, i_bit, i_clear,
        input  o_lock, o_state, o_errors, o_bits, o_lock_losses
    );

    modport slave (
        input  i_valid, i_enable, i_bit, i_clear,
        output o_lock, o_state, o_errors, o_bits, o_lock_losses
    );
endinterface

`default_nettype wire

// File: rtl/prbs9_checker_win_err_monitor.sv
// ============================================================================
// prbs9_checker_win_err_monitor: counts errors per WIN-bit window, flags loss of lock
// Rev 1.0
// ============================================================================
`default_nettype none

module prbs9_checker_win_err_monitor #(
    parameter int WIN     = 128,
    parameter int ERR_THR = 16
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_step,
    input  wire logic i_err,
    input  wire logic i_clear_win,
    output logic      o_loss
);
    localparam int CNT_W = $clog2(WIN + 1);
    localparam int ERR_W = $clog2(ERR_THR + 1);

    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [ERR_W-1:0] win_err_q, win_err_d;

    // Combinational so the owning FSM can leave LOCKED on the offending step itself.
    assign o_loss = i_step & i_err & (win_err_q == ERR_W'(ERR_THR - 1));

    always_comb begin
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        if (i_clear_win || o_loss) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end else if (i_step) begin
            if (win_cnt_q == CNT_W'(WIN - 1)) begin
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
                if (i_err) begin
                    win_err_d = win_err_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prbs9_checker.sv
// ============================================================================
// prbs9_checker: self-synchronizing x^9+x^5+1 checker with saturating BER counters
// Rev 1.0
// ============================================================================
`default_nettype none

module prbs9_checker
    import prbs9_checker_pkg::*;
#(
    parameter int NB_COUNT = 64,
    parameter int LOCK_LEN = 32,
    parameter int WIN      = 128,
    parameter int ERR_THR  = 16
) (
    input  wire logic       clock,
    input  wire logic       reset,
    prbs9_checker_if.slave  bus
);
    localparam int FILL_W = $clog2(PRBS9_LEN + 1);
    localparam int GOOD_W = $clog2(LOCK_LEN + 1);

    state_t              state_q, state_d;
    logic [PRBS9_LEN-1:0] h_q, h_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [NB_COUNT-1:0] errors_q, errors_d;
    logic [NB_COUNT-1:0] bits_q, bits_d;
    logic [LOSS_W-1:0]   losses_q, losses_d;

    logic w_step;
    logic w_pred;
    logic w_err;
    logic w_locked_step;
    logic w_clear_win;
    logic w_loss;

    assign w_step        = bus.i_valid & bus.i_enable;
    assign w_pred        = prbs9_pred(h_q);
    assign w_err         = bus.i_bit ^ w_pred;
    assign w_locked_step = w_step & (state_q == ST_LOCKED);

    prbs9_checker_win_err_monitor #(
        .WIN     (WIN),
        .ERR_THR (ERR_THR)
    ) u_win_mon (
        .clock       (clock),
        .reset       (reset),
        .i_step      (w_locked_step),
        .i_err       (w_err),
        .i_clear_win (w_clear_win),
        .o_loss      (w_loss)
    );

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_d      = fill_q;
        good_d      = good_q;
        errors_d    = errors_q;
        bits_d      = bits_q;
        losses_d    = losses_q;
        w_clear_win = 1'b0;

        if (w_step) begin
            case (state_q)
                ST_FILL: begin
                    h_d = {h_q[PRBS9_LEN-2:0], bus.i_bit};
                    if (fill_q == FILL_W'(PRBS9_LEN - 1)) begin
                        fill_d = '0;
                        if (h_d != '0) begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    h_d    = {h_q[PRBS9_LEN-2:0], bus.i_bit};
                    good_d = w_err ? '0 : good_q + 1'b1;
                    // An all-zero history would self-predict zeros forever; refill instead.
                    if (h_d == '0) begin
                        state_d = ST_FILL;
                        good_d  = '0;
                    end else if (!w_err && good_q == GOOD_W'(LOCK_LEN - 1)) begin
                        state_d     = ST_LOCKED;
                        good_d      = '0;
                        w_clear_win = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Feed back the prediction so a received error never enters the history.
                    h_d    = {h_q[PRBS9_LEN-2:0], w_pred};
                    bits_d = (bits_q == '1) ? bits_q : bits_q + 1'b1;
                    if (w_err) begin
                        errors_d = (errors_q == '1) ? errors_q : errors_q + 1'b1;
                    end
                    if (w_loss) begin
                        state_d  = ST_FILL;
                        h_d      = '0;
                        fill_d   = '0;
                        good_d   = '0;
                        losses_d = (losses_q == '1) ? losses_q : losses_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    h_d     = '0;
                    fill_d  = '0;
                    good_d  = '0;
                end
            endcase
        end

        if (bus.i_clear) begin
            errors_d = '0;
            bits_d   = '0;
            losses_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FILL;
            h_q      <= '0;
            fill_q   <= '0;
            good_q   <= '0;
            errors_q <= '0;
            bits_q   <= '0;
            losses_q <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            fill_q   <= fill_d;
            good_q   <= good_d;
            errors_q <= errors_d;
            bits_q   <= bits_d;
            losses_q <= losses_d;
        end
    end

    assign bus.o_lock        = (state_q == ST_LOCKED);
    assign bus.o_state       = state_q;
    assign bus.o_errors      = errors_q;
    assign bus.o_bits        = bits_q;
    assign bus.o_lock_losses = losses_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs9_checker.sv
// ============================================================================
// tb_prbs9_checker: directed scenarios for lock, error counting, loss, clear, reset
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prbs9_checker;

    localparam int NB = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    prbs9_checker_if #(.NB_COUNT(NB)) bus ();

    prbs9_checker #(
        .NB_COUNT (NB),
        .LOCK_LEN (32),
        .WIN      (128),
        .ERR_THR  (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [8:0] gen;

    // One symbol strobe, then gap idle clocks; returns 1 time unit after an edge.
    task automatic drive_step(input logic b, input int gap);
        bus.i_valid = 1'b1;
        bus.i_bit   = b;
        @(posedge clock);
        #1;
        bus.i_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic prbs_step(input logic flip, input int gap);
        logic b;
        b   = gen[8] ^ gen[4];
        gen = {gen[7:0], b};
        drive_step(b ^ flip, gap);
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_bit    = 1'b0;
        bus.i_clear  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        gen   = 9'h1AA;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_bit    = 1'b0;
        bus.i_clear  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (bus.o_lock !== 1'b0 || bus.o_state !== 2'd0 || bus.o_errors !== 64'd0 ||
            bus.o_bits !== 64'd0 || bus.o_lock_losses !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: lock=%0d state=%0d err=%0d bits=%0d loss=%0d, want all 0",
                     bus.o_lock, bus.o_state, bus.o_errors, bus.o_bits, bus.o_lock_losses);
        end
        reset = 1'b0;
        gen   = 9'h1AA;
    endtask

    task automatic test_clean_lock();
        for (int i = 1; i <= 1000; i++) begin
            prbs_step(1'b0, 3);
            if (i == 8) begin
                total++;
                if (bus.o_state !== 2'd0) begin
                    bad++;
                    $display("FAIL fill_step8: state=%0d want 0", bus.o_state);
                end
            end
            if (i == 9) begin
                total++;
                if (bus.o_state !== 2'd1) begin
                    bad++;
                    $display("FAIL verify_step9: state=%0d want 1", bus.o_state);
                end
            end
            if (i == 40) begin
                total++;
                if (bus.o_lock !== 1'b0) begin
                    bad++;
                    $display("FAIL lock_step40: lock=%0d want 0", bus.o_lock);
                end
            end
            if (i == 41) begin
                total++;
                if (bus.o_lock !== 1'b1 || bus.o_state !== 2'd2 || bus.o_bits !== 64'd0) begin
                    bad++;
                    $display("FAIL lock_step41: lock=%0d state=%0d bits=%0d want 1 2 0",
                             bus.o_lock, bus.o_state, bus.o_bits);
                end
            end
        end
        total++;
        if (bus.o_errors !== 64'd0 || bus.o_bits !== 64'd959 || bus.o_lock !== 1'b1) begin
            bad++;
            $display("FAIL clean_1000: err=%0d bits=%0d lock=%0d want 0 959 1",
                     bus.o_errors, bus.o_bits, bus.o_lock);
        end
    endtask

    task automatic test_single_error();
        prbs_step(1'b1, 0);
        total++;
        if (bus.o_errors !== 64'd1 || bus.o_lock !== 1'b1 || bus.o_bits !== 64'd960) begin
            bad++;
            $display("FAIL single_err: err=%0d lock=%0d bits=%0d want 1 1 960",
                     bus.o_errors, bus.o_lock, bus.o_bits);
        end
        for (int i = 0; i < 50; i++) prbs_step(1'b0, 0);
        total++;
        if (bus.o_errors !== 64'd1 || bus.o_lock !== 1'b1 || bus.o_bits !== 64'd1010) begin
            bad++;
            $display("FAIL single_err_after: err=%0d lock=%0d bits=%0d want 1 1 1010",
                     bus.o_errors, bus.o_lock, bus.o_bits);
        end
    endtask

    task automatic test_burst_loss();
        apply_reset();
        for (int i = 0; i < 41; i++) prbs_step(1'b0, 0);
        for (int i = 1; i <= 15; i++) prbs_step(1'b1, 0);
        total++;
        if (bus.o_lock !== 1'b1 || bus.o_errors !== 64'd15) begin
            bad++;
            $display("FAIL burst_15: lock=%0d err=%0d want 1 15", bus.o_lock, bus.o_errors);
        end
        prbs_step(1'b1, 0);
        total++;
        if (bus.o_lock !== 1'b0 || bus.o_state !== 2'd0 || bus.o_errors !== 64'd16 ||
            bus.o_lock_losses !== 8'd1 || bus.o_bits !== 64'd16) begin
            bad++;
            $display("FAIL burst_16: lock=%0d state=%0d err=%0d loss=%0d bits=%0d want 0 0 16 1 16",
                     bus.o_lock, bus.o_state, bus.o_errors, bus.o_lock_losses, bus.o_bits);
        end
        for (int i = 0; i < 40; i++) prbs_step(1'b0, 0);
        total++;
        if (bus.o_lock !== 1'b0) begin
            bad++;
            $display("FAIL relock_40: lock=%0d want 0", bus.o_lock);
        end
        prbs_step(1'b0, 0);
        total++;
        if (bus.o_lock !== 1'b1 || bus.o_bits !== 64'd16 || bus.o_errors !== 64'd16) begin
            bad++;
            $display("FAIL relock_41: lock=%0d bits=%0d err=%0d want 1 16 16",
                     bus.o_lock, bus.o_bits, bus.o_errors);
        end
    endtask

    task automatic test_reset_mid_lock();
        reset = 1'b1;
        #2;
        total++;
        if (bus.o_lock !== 1'b0 || bus.o_state !== 2'd0 || bus.o_errors !== 64'd0 ||
            bus.o_bits !== 64'd0 || bus.o_lock_losses !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: lock=%0d state=%0d err=%0d bits=%0d loss=%0d want all 0",
                     bus.o_lock, bus.o_state, bus.o_errors, bus.o_bits, bus.o_lock_losses);
        end
        bus.i_valid = 1'b1;
        bus.i_bit   = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (bus.o_state !== 2'd0 || bus.o_bits !== 64'd0) begin
            bad++;
            $display("FAIL reset_held: state=%0d bits=%0d want 0 0", bus.o_state, bus.o_bits);
        end
        bus.i_valid = 1'b0;
        reset       = 1'b0;
        for (int i = 0; i < 40; i++) prbs_step(1'b0, 0);
        total++;
        if (bus.o_lock !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_40: lock=%0d want 0", bus.o_lock);
        end
        prbs_step(1'b0, 0);
        total++;
        if (bus.o_lock !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_41: lock=%0d want 1", bus.o_lock);
        end
    endtask

    task automatic test_window_boundary();
        apply_reset();
        for (int i = 0; i < 41; i++) prbs_step(1'b0, 0);
        for (int i = 0; i < 15; i++) prbs_step(1'b1, 0);
        for (int i = 0; i < 113; i++) prbs_step(1'b0, 0);
        for (int i = 0; i < 15; i++) prbs_step(1'b1, 0);
        total++;
        if (bus.o_lock !== 1'b1 || bus.o_errors !== 64'd30) begin
            bad++;
            $display("FAIL window_roll: lock=%0d err=%0d want 1 30", bus.o_lock, bus.o_errors);
        end
        prbs_step(1'b1, 0);
        total++;
        if (bus.o_lock !== 1'b0 || bus.o_errors !== 64'd31 || bus.o_lock_losses !== 8'd1 ||
            bus.o_bits !== 64'd144) begin
            bad++;
            $display("FAIL window_loss: lock=%0d err=%0d loss=%0d bits=%0d want 0 31 1 144",
                     bus.o_lock, bus.o_errors, bus.o_lock_losses, bus.o_bits);
        end
    endtask

    task automatic test_clear_with_step();
        for (int i = 0; i < 41; i++) prbs_step(1'b0, 0);
        for (int i = 0; i < 5; i++) prbs_step(1'b1, 0);
        total++;
        if (bus.o_errors !== 64'd36 || bus.o_bits !== 64'd149 || bus.o_lock !== 1'b1) begin
            bad++;
            $display("FAIL pre_clear: err=%0d bits=%0d lock=%0d want 36 149 1",
                     bus.o_errors, bus.o_bits, bus.o_lock);
        end
        bus.i_clear = 1'b1;
        prbs_step(1'b1, 0);
        bus.i_clear = 1'b0;
        total++;
        if (bus.o_errors !== 64'd0 || bus.o_bits !== 64'd0 || bus.o_lock_losses !== 8'd0 ||
            bus.o_lock !== 1'b1) begin
            bad++;
            $display("FAIL clear_step: err=%0d bits=%0d loss=%0d lock=%0d want 0 0 0 1",
                     bus.o_errors, bus.o_bits, bus.o_lock_losses, bus.o_lock);
        end
        prbs_step(1'b0, 0);
        total++;
        if (bus.o_bits !== 64'd1 || bus.o_errors !== 64'd0) begin
            bad++;
            $display("FAIL after_clear: bits=%0d err=%0d want 1 0", bus.o_bits, bus.o_errors);
        end
    endtask

    task automatic test_enable_freeze();
        bus.i_enable = 1'b0;
        for (int i = 0; i < 10; i++) drive_step(~(gen[8] ^ gen[4]), 0);
        total++;
        if (bus.o_bits !== 64'd1 || bus.o_errors !== 64'd0 || bus.o_lock !== 1'b1) begin
            bad++;
            $display("FAIL enable_low: bits=%0d err=%0d lock=%0d want 1 0 1",
                     bus.o_bits, bus.o_errors, bus.o_lock);
        end
        bus.i_enable = 1'b1;
        prbs_step(1'b0, 0);
        total++;
        if (bus.o_bits !== 64'd2 || bus.o_errors !== 64'd0) begin
            bad++;
            $display("FAIL enable_resume: bits=%0d err=%0d want 2 0", bus.o_bits, bus.o_errors);
        end
    endtask

    task automatic test_constant_input();
        logic seen;
        apply_reset();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            drive_step(1'b0, 0);
            if (bus.o_state == 2'd2 || bus.o_lock) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || bus.o_state !== 2'd0) begin
            bad++;
            $display("FAIL const_zero: locked_seen=%0d state=%0d want 0 0", seen, bus.o_state);
        end
        apply_reset();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            drive_step(1'b1, 0);
            if (bus.o_state == 2'd2 || bus.o_lock) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || bus.o_state !== 2'd1) begin
            bad++;
            $display("FAIL const_one: locked_seen=%0d state=%0d want 0 1", seen, bus.o_state);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst_loss();
        test_reset_mid_lock();
        test_window_boundary();
        test_clear_with_step();
        test_enable_freeze();
        test_constant_input();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
